// File: rtl/secded_pkg.sv
// Shared SEC-DED definitions: parity-width sizing, Hamming position map and
// the per-word status type used by the decoder pipeline.
package secded_pkg;

  typedef enum logic [1:0] {CLEAN, SEC, DED} status_t;

  // Smallest r with 2^r >= data_w + r + 1; scanned downward so the smallest wins.
  function automatic int calc_pw(input int data_w);
    int pw;
    pw = 0;
    for (int r = 7; r >= 1; r--) begin
      if ((1 << r) >= data_w + r + 1) pw = r;
    end
    return pw;
  endfunction

  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // Hamming position carrying data bit idx (non-power-of-two positions, ascending).
  function automatic int data_pos(input int idx);
    int pos;
    int cnt;
    pos = 0;
    cnt = 0;
    for (int p = 1; p < 128; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational syndrome and overall-parity generator for an extended Hamming
// codeword; bit 0 is the overall parity bit, bits 1.. are Hamming positions.
module secded_syndrome #(
  parameter int CODE_W = 13,
  parameter int P_W    = 4
) (
  input  logic [CODE_W-1:0] in_code,
  output logic [P_W-1:0]    syndrome,
  output logic              parity_odd
);

  always_comb begin
    syndrome = '0;
    for (int i = 1; i < CODE_W; i++) begin
      if (in_code[i]) syndrome = syndrome ^ P_W'(i);
    end
  end

  assign parity_odd = ^in_code;

endmodule

// File: rtl/secded_decoder_pipe.sv
// Two-stage SEC-DED decoder with valid/ready flow control and saturating error
// counters. Define SECDED_ERRLOG_EN to add a sticky first-error log.
module secded_decoder_pipe
  import secded_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int CNT_W  = 8,
  localparam int P_W    = calc_pw(DATA_W),
  localparam int CODE_W = DATA_W + P_W + 1
) (
  input  logic              CLKb,
  input  logic              RSTb,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sec,
  output logic              out_ded,
  output logic [P_W-1:0]    out_pos,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  sec_count,
`ifdef SECDED_ERRLOG_EN
  output logic [CNT_W-1:0]  ded_count,
  output logic              log_valid,
  output logic              log_ded,
  output logic [P_W-1:0]    log_syn
`else
  output logic [CNT_W-1:0]  ded_count
`endif
);

  logic              advance, xfer;
  logic [P_W-1:0]    syn_c;
  logic              par_c;
  logic              s1_valid_q, s1_valid_d;
  logic [CODE_W-1:0] s1_code_q, s1_code_d;
  logic [P_W-1:0]    s1_syn_q, s1_syn_d;
  logic              s1_par_q, s1_par_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_sec_q, out_sec_d;
  logic              out_ded_q, out_ded_d;
  logic [P_W-1:0]    out_pos_q, out_pos_d;
  logic [CNT_W-1:0]  sec_cnt_q, sec_cnt_d;
  logic [CNT_W-1:0]  ded_cnt_q, ded_cnt_d;
  status_t           status;
  logic [P_W-1:0]    fix_pos;
  logic [CODE_W-1:0] fixed_code;
  logic [DATA_W-1:0] fixed_data;

  secded_syndrome #(.CODE_W(CODE_W), .P_W(P_W)) u_syndrome (
    .in_code    (in_code),
    .syndrome   (syn_c),
    .parity_odd (par_c)
  );

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;
  assign xfer     = out_valid_q && out_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_syn_d   = s1_syn_q;
    s1_par_d   = s1_par_q;
    if (advance) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_code_d = in_code;
        s1_syn_d  = syn_c;
        s1_par_d  = par_c;
      end
    end
  end

  // A non-zero syndrome with odd parity points past the codeword when it
  // names a position that does not exist; that can only be a multi-bit error.
  always_comb begin
    status  = CLEAN;
    fix_pos = '0;
    if (s1_syn_q == '0) begin
      if (s1_par_q) status = SEC;
    end else if (s1_par_q && (int'(s1_syn_q) < CODE_W)) begin
      status  = SEC;
      fix_pos = s1_syn_q;
    end else begin
      status = DED;
    end
    fixed_code = s1_code_q;
    for (int i = 1; i < CODE_W; i++) begin
      if (status == SEC && int'(fix_pos) == i) fixed_code[i] = ~s1_code_q[i];
    end
    for (int k = 0; k < DATA_W; k++) begin
      fixed_data[k] = fixed_code[data_pos(k)];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sec_d   = out_sec_q;
    out_ded_d   = out_ded_q;
    out_pos_d   = out_pos_q;
    if (advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = fixed_data;
        out_sec_d  = (status == SEC);
        out_ded_d  = (status == DED);
        out_pos_d  = fix_pos;
      end
    end
  end

  always_comb begin
    sec_cnt_d = sec_cnt_q;
    ded_cnt_d = ded_cnt_q;
    if (cnt_clr) begin
      sec_cnt_d = '0;
      ded_cnt_d = '0;
    end else if (xfer) begin
      if (out_sec_q && sec_cnt_q != '1) sec_cnt_d = sec_cnt_q + CNT_W'(1);
      if (out_ded_q && ded_cnt_q != '1) ded_cnt_d = ded_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(negedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      s1_valid_q  <= 1'b0;
      s1_code_q   <= '0;
      s1_syn_q    <= '0;
      s1_par_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sec_q   <= 1'b0;
      out_ded_q   <= 1'b0;
      out_pos_q   <= '0;
      sec_cnt_q   <= '0;
      ded_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_code_q   <= s1_code_d;
      s1_syn_q    <= s1_syn_d;
      s1_par_q    <= s1_par_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sec_q   <= out_sec_d;
      out_ded_q   <= out_ded_d;
      out_pos_q   <= out_pos_d;
      sec_cnt_q   <= sec_cnt_d;
      ded_cnt_q   <= ded_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sec   = out_sec_q;
  assign out_ded   = out_ded_q;
  assign out_pos   = out_pos_q;
  assign sec_count = sec_cnt_q;
  assign ded_count = ded_cnt_q;

`ifdef SECDED_ERRLOG_EN
  logic [P_W-1:0] out_syn_q, out_syn_d;
  logic           log_valid_q, log_valid_d;
  logic           log_ded_q, log_ded_d;
  logic [P_W-1:0] log_syn_q, log_syn_d;

  // The stage-2 syndrome travels with the word so the log matches the transfer.
  always_comb begin
    out_syn_d   = out_syn_q;
    log_valid_d = log_valid_q;
    log_ded_d   = log_ded_q;
    log_syn_d   = log_syn_q;
    if (advance && s1_valid_q) out_syn_d = s1_syn_q;
    if (cnt_clr) begin
      log_valid_d = 1'b0;
      log_ded_d   = 1'b0;
      log_syn_d   = '0;
    end else if (xfer && (out_sec_q || out_ded_q) && !log_valid_q) begin
      log_valid_d = 1'b1;
      log_ded_d   = out_ded_q;
      log_syn_d   = out_syn_q;
    end
  end

  always_ff @(negedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      out_syn_q   <= '0;
      log_valid_q <= 1'b0;
      log_ded_q   <= 1'b0;
      log_syn_q   <= '0;
    end else begin
      out_syn_q   <= out_syn_d;
      log_valid_q <= log_valid_d;
      log_ded_q   <= log_ded_d;
      log_syn_q   <= log_syn_d;
    end
  end

  assign log_valid = log_valid_q;
  assign log_ded   = log_ded_q;
  assign log_syn   = log_syn_q;
`endif

endmodule

// File: tb/tb_secded_decoder_pipe.sv
// Bench for secded_decoder_pipe: directed vectors plus random traffic scored
// against a position-arithmetic decode model; a CNT_W=2 copy checks saturation.
module tb_secded_decoder_pipe;

  localparam int DATA_W = 8;
  localparam int CODE_W = 13;

  typedef struct packed {
    logic [7:0] data;
    logic       sec;
    logic       ded;
    logic [3:0] pos;
    logic [3:0] syn;
  } exp_t;

  logic        CLKb = 1'b0;
  logic        RSTb;
  logic        in_valid, out_ready, cnt_clr;
  logic [12:0] in_code;
  logic        in_ready, out_valid, out_sec, out_ded;
  logic [7:0]  out_data, sec_count, ded_count;
  logic [3:0]  out_pos;
  logic        in_ready2, out_valid2, out_sec2, out_ded2;
  logic [7:0]  out_data2;
  logic [3:0]  out_pos2;
  logic [1:0]  sec_count2, ded_count2;
`ifdef SECDED_ERRLOG_EN
  logic        log_valid, log_ded, log_valid2, log_ded2;
  logic [3:0]  log_syn, log_syn2;
  logic        logValid, logDed;
  logic [3:0]  logSyn;
`endif

  always #5 CLKb = ~CLKb;

  secded_decoder_pipe #(.DATA_W(8), .CNT_W(8)) u_dut (
    .CLKb(CLKb), .RSTb(RSTb), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sec(out_sec),
    .out_ded(out_ded), .out_pos(out_pos), .cnt_clr(cnt_clr), .sec_count(sec_count),
`ifdef SECDED_ERRLOG_EN
    .log_valid(log_valid), .log_ded(log_ded), .log_syn(log_syn),
`endif
    .ded_count(ded_count)
  );

  secded_decoder_pipe #(.DATA_W(8), .CNT_W(2)) u_dut2 (
    .CLKb(CLKb), .RSTb(RSTb), .in_valid(in_valid), .in_ready(in_ready2), .in_code(in_code),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_sec(out_sec2),
    .out_ded(out_ded2), .out_pos(out_pos2), .cnt_clr(cnt_clr), .sec_count(sec_count2),
`ifdef SECDED_ERRLOG_EN
    .log_valid(log_valid2), .log_ded(log_ded2), .log_syn(log_syn2),
`endif
    .ded_count(ded_count2)
  );

  int   compared = 0;
  int   mismatched = 0;
  int   modelSec, modelDed, modelSec2, modelDed2;
  int   xferCount;
  int   dataPos [8] = '{3, 5, 6, 7, 9, 10, 11, 12};
  exp_t expQ [$];
  logic prevStall;
  logic [14:0] heldOut;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected result from the codeword rules: XOR of set positions, popcount parity.
  function automatic exp_t modelDecode(input logic [12:0] code);
    exp_t e;
    int   syn, flip;
    e    = '0;
    syn  = 0;
    flip = -1;
    for (int p = 1; p < CODE_W; p++) if (code[p]) syn = syn ^ p;
    e.syn = syn[3:0];
    if ($countones(code) % 2 == 1) begin
      if (syn < CODE_W) begin
        e.sec = 1'b1;
        e.pos = syn[3:0];
        flip  = syn;
      end else begin
        e.ded = 1'b1;
      end
    end else if (syn != 0) begin
      e.ded = 1'b1;
    end
    for (int k = 0; k < DATA_W; k++)
      e.data[k] = (dataPos[k] == flip) ? ~code[dataPos[k]] : code[dataPos[k]];
    return e;
  endfunction

  function automatic logic [12:0] encode(input logic [7:0] d);
    logic [12:0] c;
    int par;
    c = '0;
    for (int k = 0; k < DATA_W; k++) c[dataPos[k]] = d[k];
    for (int j = 0; j < 4; j++) begin
      par = 0;
      for (int p = 1; p < CODE_W; p++) if (((p >> j) & 1) == 1 && c[p]) par = par ^ 1;
      c[1 << j] = par[0];
    end
    c[0] = ^c;
    return c;
  endfunction

  function automatic logic [12:0] genCode();
    logic [12:0] c;
    int a, b;
    c = encode(8'($urandom));
    a = $urandom_range(0, 12);
    b = (a + $urandom_range(1, 12)) % CODE_W;
    case ($urandom_range(0, 3))
      1: c[a] = ~c[a];
      2: begin c[a] = ~c[a]; c[b] = ~c[b]; end
      3: c = 13'($urandom);
      default: ;
    endcase
    return c;
  endfunction

  // One clock cycle: drive on the rising edge, score what the next falling edge does.
  task automatic applyStimulus(input logic vin, input logic [12:0] code, input logic ordy,
                               input logic clr, output logic acc);
    exp_t e;
    @(posedge CLKb);
    in_valid  = vin;
    in_code   = code;
    out_ready = ordy;
    cnt_clr   = clr;
    #1;
    checkOutput("sec_count", 32'(sec_count), 32'(modelSec));
    checkOutput("ded_count", 32'(ded_count), 32'(modelDed));
    checkOutput("sec_count_w2", 32'(sec_count2), 32'(modelSec2));
    checkOutput("ded_count_w2", 32'(ded_count2), 32'(modelDed2));
`ifdef SECDED_ERRLOG_EN
    checkOutput("log_valid", 32'(log_valid), 32'(logValid));
    checkOutput("log_ded", 32'(log_ded), 32'(logDed));
    checkOutput("log_syn", 32'(log_syn), 32'(logSyn));
`endif
    if (prevStall) checkOutput("hold_stable", 32'({out_valid, out_data, out_sec, out_ded, out_pos}), 32'(heldOut));
    prevStall = out_valid && !ordy;
    heldOut   = {out_valid, out_data, out_sec, out_ded, out_pos};
    acc = vin && in_ready;
    if (acc) expQ.push_back(modelDecode(code));
    e = '0;
    if (out_valid && ordy) begin
      if (expQ.size() == 0) begin
        checkOutput("spurious_out", 32'(1), 32'(0));
      end else begin
        e = expQ.pop_front();
        checkOutput("out_data", 32'(out_data), 32'(e.data));
        checkOutput("out_sec", 32'(out_sec), 32'(e.sec));
        checkOutput("out_ded", 32'(out_ded), 32'(e.ded));
        checkOutput("out_pos", 32'(out_pos), 32'(e.pos));
        xferCount++;
      end
    end
    if (clr) begin
      modelSec = 0; modelDed = 0; modelSec2 = 0; modelDed2 = 0;
`ifdef SECDED_ERRLOG_EN
      logValid = 1'b0; logDed = 1'b0; logSyn = '0;
`endif
    end else begin
      if (e.sec) begin
        if (modelSec < 255) modelSec++;
        if (modelSec2 < 3) modelSec2++;
      end
      if (e.ded) begin
        if (modelDed < 255) modelDed++;
        if (modelDed2 < 3) modelDed2++;
      end
`ifdef SECDED_ERRLOG_EN
      if ((e.sec || e.ded) && !logValid) begin
        logValid = 1'b1; logDed = e.ded; logSyn = e.syn;
      end
`endif
    end
  endtask

  task automatic resetModel();
    expQ.delete();
    modelSec = 0; modelDed = 0; modelSec2 = 0; modelDed2 = 0;
    prevStall = 1'b0;
    heldOut = '0;
`ifdef SECDED_ERRLOG_EN
    logValid = 1'b0; logDed = 1'b0; logSyn = '0;
`endif
  endtask

  task automatic runDirected(input string tag, input logic [12:0] code, input logic [7:0] eData,
                             input logic eSec, input logic eDed, input logic [3:0] ePos);
    logic acc;
    applyStimulus(1'b1, code, 1'b1, 1'b0, acc);
    checkOutput({tag, "_accept"}, 32'(acc), 32'(1));
    applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
    checkOutput({tag, "_lat1"}, 32'(out_valid), 32'(0));
    applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
    checkOutput({tag, "_lat2"}, 32'(out_valid), 32'(1));
    checkOutput({tag, "_data"}, 32'(out_data), 32'(eData));
    checkOutput({tag, "_sec"}, 32'(out_sec), 32'(eSec));
    checkOutput({tag, "_ded"}, 32'(out_ded), 32'(eDed));
    checkOutput({tag, "_pos"}, 32'(out_pos), 32'(ePos));
  endtask

  initial begin
    logic        acc;
    logic [12:0] words [3];
    int          idx;
    xferCount = 0;
    resetModel();
    RSTb = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b0; cnt_clr = 1'b0;
    repeat (3) @(posedge CLKb);
    #2;
    checkOutput("rst_in_ready", 32'(in_ready), 32'(1));
    checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
    checkOutput("rst_out_fields", 32'({out_data, out_sec, out_ded, out_pos}), 32'(0));
    checkOutput("rst_counters", 32'({sec_count, ded_count}), 32'(0));
    #1 RSTb = 1'b1;

    runDirected("clean", 13'h1EEE, 8'hFF, 1'b0, 1'b0, 4'd0);
    runDirected("sec_pos6", 13'h1EAE, 8'hFF, 1'b1, 1'b0, 4'd6);
    runDirected("sec_pos0", 13'h0001, 8'h00, 1'b1, 1'b0, 4'd0);
    runDirected("ded_double", 13'h1EE8, 8'hFF, 1'b0, 1'b1, 4'd0);
    runDirected("ded_syn14", 13'h1005, 8'h80, 1'b0, 1'b1, 4'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
    checkOutput("dir_sec_count", 32'(sec_count), 32'(2));
    checkOutput("dir_ded_count", 32'(ded_count), 32'(2));

    applyStimulus(1'b0, '0, 1'b1, 1'b1, acc);
    repeat (5) applyStimulus(1'b1, 13'h1EAE, 1'b1, 1'b0, acc);
    repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
    checkOutput("sat_count_w8", 32'(sec_count), 32'(5));
    checkOutput("sat_count_w2", 32'(sec_count2), 32'(3));

    applyStimulus(1'b1, 13'h1EAE, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, acc);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
    checkOutput("clr_priority", 32'(sec_count), 32'(0));

    words[0] = 13'h0000; words[1] = 13'h1EEE; words[2] = 13'h0000;
    idx = 0;
    xferCount = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      applyStimulus(idx < 3, words[idx % 3], cyc >= 5, 1'b0, acc);
      if (cyc >= 2 && cyc <= 4) checkOutput("stall_in_ready", 32'(in_ready), 32'(0));
      if (acc) idx++;
    end
    checkOutput("stream_count", 32'(xferCount), 32'(3));
    checkOutput("stream_drained", 32'(expQ.size()), 32'(0));

    applyStimulus(1'b1, 13'h1EEE, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 13'h1EAE, 1'b1, 1'b0, acc);
    #2 RSTb = 1'b0;
    #4;
    checkOutput("rst_inflight_valid", 32'(out_valid), 32'(0));
    RSTb = 1'b1;
    resetModel();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
      checkOutput("post_rst_valid", 32'(out_valid), 32'(0));
      checkOutput("post_rst_ready", 32'(in_ready), 32'(1));
    end

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, genCode(), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 31) == 0, acc);
    end
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
    checkOutput("final_drained", 32'(expQ.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
